alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/control_pkg.sv | 55 +++++
 rtl/branch_compare.sv | 31 +++
 rtl/alu_exec_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared control encodings for the execute stage: ALU/operand/branch selects and exec FSM states.
package control_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned SHAMT_W      = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } e_alu_operation_sel;

  typedef enum logic [1:0] {
    ALU_RS1  = 2'd0,
    ALU_PC   = 2'd1,
    ALU_ZERO = 2'd2
  } e_alu_operand_a_sel;

  typedef enum logic {
    ALU_RS2 = 1'b0,
    ALU_IMM = 1'b1
  } e_alu_operand_b_sel;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'd0,
    CMP_BNE  = 3'd1,
    CMP_BLT  = 3'd4,
    CMP_BGE  = 3'd5,
    CMP_BLTU = 3'd6,
    CMP_BGEU = 3'd7
  } e_branch_operation_sel;

  typedef enum logic {
    BRANCH_NOT_TAKEN = 1'b0,
    BRANCH_TAKEN     = 1'b1
  } e_branch_result;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_SHIFT,
    EX_DONE
  } e_exec_state;

  function automatic logic is_shift_op(logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational branch decision on raw rs1/rs2; undefined compares and non-branches are not taken.
module branch_compare
  import control_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      branch_op_sel,
  input  logic            is_branch,
  output logic            branch_result
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (branch_op_sel)
      CMP_BEQ:  taken = (rs1 == rs2);
      CMP_BNE:  taken = (rs1 != rs2);
      CMP_BLT:  taken = ($signed(rs1) < $signed(rs2));
      CMP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      CMP_BLTU: taken = (rs1 < rs2);
      CMP_BGEU: taken = (rs1 >= rs2);
      default:  taken = 1'b0;
    endcase
  end

  assign branch_result = (is_branch && taken) ? BRANCH_TAKEN : BRANCH_NOT_TAKEN;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute unit: single-cycle ALU ops, bit-serial shifts (one bit per cycle), registered branch
// decision, valid/ready handshake on both sides.
module alu_exec_unit
  import control_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op_sel,
  input  logic [1:0]      op_a_sel,
  input  logic            op_b_sel,
  input  logic            is_branch,
  input  logic [2:0]      branch_op_sel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            branch_result
);

  e_exec_state         state_q, state_d;
  logic [XLEN-1:0]     work_q, work_d;
  logic [XLEN-1:0]     alu_result_q, alu_result_d;
  logic [3:0]          op_q, op_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                branch_pend_q, branch_pend_d;
  logic                branch_result_q, branch_result_d;

  logic [XLEN-1:0]     opa, opb, alu_comb, shift_one;
  logic [SHAMT_W-1:0]  shamt;
  logic                br_comb, accept, shift_start;

  always_comb begin
    opa = '0;
    case (op_a_sel)
      ALU_RS1: opa = rs1_data;
      ALU_PC:  opa = pc;
      default: opa = '0;
    endcase
  end

  assign opb   = (op_b_sel == ALU_IMM) ? imm : rs2_data;
  assign shamt = opb[SHAMT_W-1:0];

  always_comb begin
    alu_comb = '0;
    case (alu_op_sel)
      ALU_ADD:  alu_comb = opa + opb;
      ALU_SUB:  alu_comb = opa - opb;
      ALU_SLT:  alu_comb = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      ALU_SLTU: alu_comb = {{(XLEN-1){1'b0}}, (opa < opb)};
      ALU_XOR:  alu_comb = opa ^ opb;
      ALU_OR:   alu_comb = opa | opb;
      ALU_AND:  alu_comb = opa & opb;
      // Only reached for a zero shift amount; nonzero shifts go through EX_SHIFT.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_comb = opa;
      default:  alu_comb = '0;
    endcase
  end

  always_comb begin
    shift_one = work_q;
    case (op_q)
      ALU_SLL: shift_one = {work_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_one = {1'b0, work_q[XLEN-1:1]};
      ALU_SRA: shift_one = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: shift_one = work_q;
    endcase
  end

  branch_compare #(
    .XLEN(XLEN)
  ) u_branch_compare (
    .rs1          (rs1_data),
    .rs2          (rs2_data),
    .branch_op_sel(branch_op_sel),
    .is_branch    (is_branch),
    .branch_result(br_comb)
  );

  assign in_ready    = !rst && ((state_q == EX_IDLE) || ((state_q == EX_DONE) && out_ready));
  assign accept      = in_valid && in_ready;
  assign shift_start = is_shift_op(alu_op_sel) && (shamt != '0);

  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    op_d            = op_q;
    cnt_d           = cnt_q;
    branch_pend_d   = branch_pend_q;
    alu_result_d    = alu_result_q;
    branch_result_d = branch_result_q;

    case (state_q)
      EX_IDLE: ;
      EX_SHIFT: begin
        work_d = shift_one;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d         = EX_DONE;
          alu_result_d    = shift_one;
          branch_result_d = branch_pend_q;
        end
      end
      EX_DONE: begin
        if (out_ready) state_d = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase

    // The branch decision is held back during a shift so both results appear together.
    if (accept) begin
      if (shift_start) begin
        state_d       = EX_SHIFT;
        work_d        = opa;
        op_d          = alu_op_sel;
        cnt_d         = shamt;
        branch_pend_d = br_comb;
      end else begin
        state_d         = EX_DONE;
        alu_result_d    = alu_comb;
        branch_result_d = br_comb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= EX_IDLE;
      work_q          <= '0;
      op_q            <= '0;
      cnt_q           <= '0;
      branch_pend_q   <= BRANCH_NOT_TAKEN;
      alu_result_q    <= '0;
      branch_result_q <= BRANCH_NOT_TAKEN;
    end else begin
      state_q         <= state_d;
      work_q          <= work_d;
      op_q            <= op_d;
      cnt_q           <= cnt_d;
      branch_pend_q   <= branch_pend_d;
      alu_result_q    <= alu_result_d;
      branch_result_q <= branch_result_d;
    end
  end

  assign out_valid     = (state_q == EX_DONE);
  assign alu_result    = alu_result_q;
  assign branch_result = branch_result_q;

endmodule
